// File: rtl/apb_pkg.sv
// apb_pkg: shared types and default sizing for the APB initiator.
package apb_pkg;
    localparam int ADDR_W_DEF      = 32;
    localparam int DATA_W_DEF      = 32;
    localparam int SEL_BIT_DEF     = 8;
    localparam int TIMEOUT_CYC_DEF = 16;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
    typedef enum logic {SLV1, SLV2} slv_t;
endpackage

// File: rtl/apb_timeout_ctr.sv
// apb_timeout_ctr: counts stalled ACCESS cycles; tc flags the last one allowed.
module apb_timeout_ctr #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tc
);
    localparam int W = $clog2(LIMIT + 1);
    logic [W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (!rst_n || clear) cnt <= '0;
        else if (enable)     cnt <= cnt + W'(1);
    end
    // tc during the LIMIT-th stalled cycle so the abort lands right after it
    assign tc = cnt == W'(LIMIT - 1);
endmodule

// File: rtl/apb_master.sv
// apb_master: single-beat APB initiator for a two-slave segment.
// APB_MASTER_TIMEOUT_EN adds an ACCESS-phase watchdog that reports rsp_err.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int SEL_BIT     = SEL_BIT_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    output logic              PWRITE,
    output logic              PSEL1,
    output logic              PSEL2,
    output logic              PENABLE,
    input  logic [DATA_W-1:0] PRDATA1,
    input  logic [DATA_W-1:0] PRDATA2,
    input  logic              PREADY1,
    input  logic              PREADY2
);
    localparam logic [ADDR_W-1:0] MASK = ~({ADDR_W{1'b1}} << SEL_BIT);

    state_t            state, next;
    slv_t              slv_q;
    logic              wr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              pready, done, abort;
    logic [DATA_W-1:0] prdata;

    assign pready = slv_q == SLV2 ? PREADY2 : PREADY1;
    assign prdata = slv_q == SLV2 ? PRDATA2 : PRDATA1;
    assign done   = state == ACCESS && pready;

`ifdef APB_MASTER_TIMEOUT_EN
    logic tc;
    apb_timeout_ctr #(.LIMIT(TIMEOUT_CYC)) u_timeout (
        .clk    (PCLK),
        .rst_n  (PRESETn),
        .clear  (state == SETUP),
        .enable (state == ACCESS && !pready),
        .tc     (tc)
    );
    assign abort = state == ACCESS && !pready && tc;
`else
    // never true; keeps TIMEOUT_CYC referenced when the watchdog is absent
    assign abort = TIMEOUT_CYC < 0;
`endif

    always_comb begin
        next = state;
        next = state == IDLE  ? (cmd_valid ? SETUP : IDLE) :
               state == SETUP ? ACCESS :
               (pready || abort) ? IDLE : ACCESS;
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state     <= IDLE;
            slv_q     <= SLV1;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= next;
            rsp_valid <= done || abort;
            if (state == IDLE && cmd_valid) begin
                slv_q   <= slv_t'(cmd_addr[SEL_BIT]);
                wr_q    <= cmd_write;
                addr_q  <= cmd_addr & MASK;
                wdata_q <= cmd_wdata;
            end
            if (done || abort) begin
                rsp_rdata <= (done && !wr_q) ? prdata : '0;
                rsp_err   <= abort;
            end
        end
    end

    // gated by PRESETn so the requester sees not-ready for the whole reset
    assign cmd_ready = state == IDLE && PRESETn;
    assign PSEL1     = state != IDLE && slv_q == SLV1;
    assign PSEL2     = state != IDLE && slv_q == SLV2;
    assign PENABLE   = state == ACCESS;
    assign PADDR     = addr_q;
    assign PWDATA    = wdata_q;
    assign PWRITE    = wr_q;
endmodule

// File: doc/apb_master.md
# apb_master

APB initiator that turns single-beat read/write commands from a local requester (GPIO/UART control logic or test sequencer) into APB transfers on the shared bus. It drives the two-slave APB segment (slave 1, slave 2) and returns read data with a one-cycle response pulse. It is the bus-side counterpart to the existing APB slave blocks.

## Interface
- ADDR_W, 32, command/PADDR address width
- DATA_W, 32, data width
- SEL_BIT, 8, cmd_addr bit that selects the slave: 0 → slave 1, 1 → slave 2
- TIMEOUT_CYC, 16, max ACCESS cycles before abort (used only with the timeout feature)
- PCLK  in  1  bus clock; all logic on rising edge
- PRESETn  in  1  synchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  byte-free word address
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  DATA_W  read data; 0 for writes
- rsp_err  out  1  transfer aborted (timeout); valid with rsp_valid
- PADDR  out  ADDR_W  cmd_addr with bits [ADDR_W-1:SEL_BIT] forced to 0
- PWDATA  out  DATA_W  write data
- PWRITE  out  1  transfer direction
- PSEL1, PSEL2  out  1 each  slave selects, one-hot or both 0
- PENABLE  out  1  access phase
- PRDATA1, PRDATA2  in  DATA_W  slave read data
- PREADY1, PREADY2  in  1 each  slave ready; only the selected one is used

## Operation
- FSM: IDLE → SETUP → ACCESS → IDLE.
- IDLE: cmd_ready=1. On handshake, latch write/addr/wdata/slave-select into registers and go to SETUP.
- SETUP: cmd_ready=0. Assert the selected PSEL, PENABLE=0, and drive PADDR/PWDATA/PWRITE from the latches. Always lasts exactly 1 cycle.
- ACCESS: PSEL held, PENABLE=1, address/data/direction held stable.
  - If the selected PREADY=1 at the edge: capture the selected PRDATA (reads) into rsp_rdata, pulse rsp_valid, go to IDLE.
  - If PREADY=0: stay in ACCESS (wait states).
- PSEL/PENABLE deassert in the IDLE cycle following ACCESS. The next command is accepted no earlier than that IDLE cycle.
- PREADY and PRDATA of the unselected slave are ignored.
- Reset values: cmd_ready=0 while PRESETn=0, 1 after. All other outputs 0. FSM=IDLE.
- Reset mid-transfer: at the first edge with PRESETn=0, all outputs go to reset values, the transfer is dropped, and no rsp_valid is produced.
- cmd_valid in a non-IDLE state is ignored (not stalled internally).

## Timing
- Handshake at edge k → SETUP during cycle k+1 → ACCESS during cycle k+2.
- With zero wait states: rsp_valid high in cycle k+3, together with IDLE and cmd_ready=1.
- Each PREADY=0 cycle in ACCESS adds 1 cycle.
- Minimum command-to-command spacing is 3 cycles.
- rsp_rdata is registered and held until the next rsp_valid.

## Configuration
- APB_MASTER_TIMEOUT_EN defined:
  - A counter clears on entering ACCESS and increments each ACCESS cycle with PREADY=0.
  - When it reaches TIMEOUT_CYC, the transfer aborts: go to IDLE, drop PSEL/PENABLE, pulse rsp_valid with rsp_err=1 and rsp_rdata=0.
  - PREADY=1 on the terminal cycle wins: normal completion, rsp_err=0.
- Macro undefined: no counter, ACCESS waits indefinitely, rsp_err tied to 0.

## Structure
- Package apb_pkg holds:
  - state enum (IDLE, SETUP, ACCESS)
  - default ADDR_W/DATA_W/SEL_BIT/TIMEOUT_CYC constants
  - slave-select encoding (SLV1, SLV2)
- Sub-module apb_timeout_ctr (clear, enable, terminal-count output) is instantiated only under APB_MASTER_TIMEOUT_EN.

## Test plan
- Write cmd_addr=0x05, wdata=0xDEADBEEF to slave 1 (zero-wait): PSEL1 high 2 cycles, PENABLE only in the 2nd, PADDR=0x05, rsp_valid at k+3, rsp_err=0.
- Read back 0x05 from slave 1: rsp_rdata=0xDEADBEEF at k+3.
- cmd_addr=0x105 write then read: PSEL2 selected, PADDR=0x05, PSEL1 never high, slave-1 location 0x05 unchanged.
- Slave holds PREADY2=0 for 3 ACCESS cycles: PENABLE high 4 cycles with PADDR/PWDATA stable; rsp_valid at k+6.
- PRESETn low during ACCESS: next edge PSEL/PENABLE=0, no rsp_valid; first command after release completes normally.
- With APB_MASTER_TIMEOUT_EN and TIMEOUT_CYC=4, PREADY stuck 0: abort after 4 ACCESS cycles, rsp_valid=1, rsp_err=1, rsp_rdata=0, bus idle afterwards.
